// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
//   Shift-add multiply or restoring shift-subtract divide, one bit per cycle.
//   The pipeline is stalled while busy. The result is returned with a valid/ack handshake.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request, sampled only when ready=1
//   op               00 MUL, 01 MULH, 10 DIV, 11 REM
//   is_signed        operands are two's complement when 1
//   a, b             multiplicand/dividend, multiplier/divisor
//   flush            abort any operation, return to IDLE
//   ack              consumer takes the result while valid=1
//   ready            1 in IDLE only
//   busy             1 in CALC/FIX/DONE (stall request)
//   valid            result available (DONE)
//   result           selected result, held stable while valid=1
//   div_zero         DIV/REM executed with b==0
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             ack,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_q, neg_d;          // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic [2*WIDTH-1:0]   acc_q, acc_d;          // product, or {rem, quo}
  logic [WIDTH-1:0]     opnd_q, opnd_d;        // |a| for multiply, |b| for divide
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 dz_q, dz_d;

  logic                 sgn_a, sgn_b, b_zero;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      dz_q      <= dz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = (op[1] && b_zero) ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == '0) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand conditioning and per-iteration arithmetic
  always_comb begin
    sgn_a   = is_signed & a[WIDTH-1];
    sgn_b   = is_signed & b[WIDTH-1];
    b_zero  = (b == '0);
    // -(2^(W-1)) wraps to itself, which read as unsigned is the correct magnitude
    abs_a   = sgn_a ? -a : a;
    abs_b   = sgn_b ? -b : b;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};

    // The shifted partial remainder needs WIDTH+1 bits; when it is >= the
    // divisor the difference always fits back into WIDTH bits.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Register updates per state
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    valid_d   = valid_q;
    dz_d      = dz_q;

    if (flush) begin
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d      = op;
            neg_d     = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a;
            cnt_d     = CW'(WIDTH - 1);
            if (op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, abs_a};
              opnd_d = abs_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, abs_b};
              opnd_d = abs_a;
            end
            if (op[1] && b_zero) begin
              result_d = op[0] ? a : '1;
              dz_d     = 1'b1;
              valid_d  = 1'b1;
            end
          end
        end
        S_CALC: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (op_q[1]) begin
            acc_d = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
          end
        end
        S_FIX: begin
          unique case (op_q)
            2'b00:   result_d = prod_fix[WIDTH-1:0];
            2'b01:   result_d = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   result_d = quo_fix;
            default: result_d = rem_fix;
          endcase
          dz_d    = 1'b0;
          valid_d = 1'b1;
        end
        S_DONE: begin
          if (ack) valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign valid    = valid_q;
  assign result   = result_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        ready, busy, valid, div_zero;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_signed(is_signed),
    .a(a), .b(b), .flush(flush), .ack(ack), .ready(ready), .busy(busy),
    .valid(valid), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op and report the cycle count until valid (start cycle = 1, -1 on timeout)
  task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, output int lat);
    @(negedge clk);
    op = o; is_signed = s; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    if (valid) lat = 1;
    else begin
      for (int i = 2; i <= 60; i++) begin
        @(posedge clk); #1;
        if (valid) begin lat = i; break; end
      end
    end
  endtask

  task automatic do_ack;
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b expected 0", div_zero); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic [1:0]  vo [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] va [6] = '{32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] vb [6] = '{32'd6, 32'd3, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] ve [6] = '{32'd42, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'h40000000, 32'h80000000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], vs[i], va[i], vb[i], lat);
      total++; if (lat != 34) $display("FAIL mul_latency[%0d]: got %0d expected 34", i, lat); else passed++;
      total++; if (result !== ve[i]) $display("FAIL mul_result[%0d]: got %h expected %h", i, result, ve[i]); else passed++;
      total++; if (div_zero !== 1'b0) $display("FAIL mul_dz[%0d]: got %b expected 0", i, div_zero); else passed++;
      do_ack();
      total++; if (valid !== 1'b0 || ready !== 1'b1)
        $display("FAIL mul_ack[%0d]: got valid=%b ready=%b expected valid=0 ready=1", i, valid, ready);
      else passed++;
      total++; if (result !== ve[i]) $display("FAIL mul_hold[%0d]: got %h expected %h", i, result, ve[i]); else passed++;
    end
  endtask

  task automatic test_div;
    logic [1:0]  vo [12] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11,
                             2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
    logic        vs [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] va [12] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd100};
    logic [31:0] vb [12] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFE, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
    logic [31:0] ve [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'h80000000, 32'd0,
                             32'd1, 32'd1, 32'h55555555, 32'd0, 32'h80000000, 32'd2};
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(vo[i], vs[i], va[i], vb[i], lat);
      total++; if (lat != 34) $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); else passed++;
      total++; if (result !== ve[i]) $display("FAIL div_result[%0d]: got %h expected %h", i, result, ve[i]); else passed++;
      total++; if (div_zero !== 1'b0) $display("FAIL div_dz[%0d]: got %b expected 0", i, div_zero); else passed++;
      do_ack();
    end
  endtask

  task automatic test_div_zero;
    logic [1:0]  vo [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] va [4] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] ve [4] = '{32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(vo[i], vs[i], va[i], 32'd0, lat);
      total++; if (lat != 1) $display("FAIL dz_latency[%0d]: got %0d expected 1", i, lat); else passed++;
      total++; if (result !== ve[i]) $display("FAIL dz_result[%0d]: got %h expected %h", i, result, ve[i]); else passed++;
      total++; if (div_zero !== 1'b1) $display("FAIL dz_flag[%0d]: got %b expected 1", i, div_zero); else passed++;
      total++; if (busy !== 1'b1 || ready !== 1'b0)
        $display("FAIL dz_busy[%0d]: got busy=%b ready=%b expected busy=1 ready=0", i, busy, ready);
      else passed++;
      do_ack();
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    // start and ack during CALC must both be ignored
    @(negedge clk);
    op = 2'b00; is_signed = 1'b0; a = 32'd7; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || ready !== 1'b0 || valid !== 1'b0)
      $display("FAIL b2b_calc: got busy=%b ready=%b valid=%b expected 1 0 0", busy, ready, valid);
    else passed++;
    @(negedge clk);
    op = 2'b10; a = 32'd1; b = 32'd0; start = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    lat = -1;
    for (int i = 3; i <= 60; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    total++; if (lat != 34) $display("FAIL b2b_latency: got %0d expected 34", lat); else passed++;
    total++; if (result !== 32'd42) $display("FAIL b2b_result: got %h expected 0000002a", result); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL b2b_dz: got %b expected 0", div_zero); else passed++;
    do_ack();
    // immediately issue the next op
    run_op(2'b11, 1'b1, 32'd7, 32'hFFFFFFFE, lat);
    total++; if (lat != 34 || result !== 32'd1)
      $display("FAIL b2b_next: got lat=%0d result=%h expected lat=34 result=00000001", lat, result);
    else passed++;
    do_ack();
  endtask

  task automatic test_flush;
    int lat;
    logic seen;
    run_op(2'b00, 1'b0, 32'd7, 32'd6, lat);
    do_ack();
    // flush during CALC iteration 10
    @(negedge clk);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL flush_calc: got ready=%b busy=%b valid=%b expected 1 0 0", ready, busy, valid);
    else passed++;
    total++; if (result !== 32'd42) $display("FAIL flush_keep: got %h expected 0000002a", result); else passed++;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL flush_novalid: got valid seen=%b expected 0", seen); else passed++;
    // flush beats start in IDLE
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL flush_start: got ready=%b busy=%b expected 1 0", ready, busy);
    else passed++;
    run_op(2'b10, 1'b0, 32'd100, 32'd7, lat);
    total++; if (lat != 34 || result !== 32'd14)
      $display("FAIL flush_restart: got lat=%0d result=%h expected lat=34 result=0000000e", lat, result);
    else passed++;
    do_ack();
    // flush in DONE beats ack; result is kept
    run_op(2'b11, 1'b0, 32'd100, 32'd7, lat);
    @(negedge clk);
    flush = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ack = 1'b0;
    total++; if (valid !== 1'b0 || ready !== 1'b1)
      $display("FAIL flush_done: got valid=%b ready=%b expected 0 1", valid, ready);
    else passed++;
    total++; if (result !== 32'd2) $display("FAIL flush_done_keep: got %h expected 00000002", result); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    op = 2'b00; is_signed = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL rstmid_ctrl: got ready=%b busy=%b valid=%b expected 1 0 0", ready, busy, valid);
    else passed++;
    total++; if (result !== 32'h0 || div_zero !== 1'b0)
      $display("FAIL rstmid_data: got result=%h dz=%b expected 0 0", result, div_zero);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 1'b0, 32'd7, 32'd6, lat);
    total++; if (lat != 34 || result !== 32'd42)
      $display("FAIL rstmid_after: got lat=%0d result=%h expected lat=34 result=0000002a", lat, result);
    else passed++;
    do_ack();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
